request_unit_mc: RTL and testbench
==================================

Name: request_unit_mc

Overview:
Parametrised multi-channel memory request unit for the datapath. It generates the instruction read enable and NCH independent data read/write enables. Data requests are latched on an instruction hit and held until the matching data hit. It adds sticky halt draining, optional fetch stalling while data is outstanding, per-channel request watchdogs and read/write conflict detection. It sits between the control unit (MemRead/MemWrite, halt) and the cache/memory-control hit signals.

Parameters:
NCH, 2, number of data request channels (1..8).
ISTALL_EN, 1, 1: iREN drops while any data request is outstanding; 0: iREN stays high regardless.
TIMEOUT, 64, cycles a data request may stay outstanding before timeout flags; 0 disables the watchdog.
TW, 8, watchdog counter width; TIMEOUT must be < 2^TW.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous, active-high reset.
halt  in  1  halt decoded by the control unit.
ihit  in  1  instruction fetch completed this cycle.
dhit  in  NCH  per-channel data access completed this cycle.
MemRead  in  NCH  per-channel data read requested by the current instruction.
MemWrite  in  NCH  per-channel data write requested by the current instruction.
iREN  out  1  instruction read enable.
dREN  out  NCH  per-channel data read enable.
dWEN  out  NCH  per-channel data write enable.
busy  out  1  OR of all dREN|dWEN.
halted  out  1  halt fully drained; sticky.
timeout  out  NCH  per-channel watchdog expired; sticky until that channel's dhit.
conflict  out  1  one-cycle pulse: some channel had MemRead&MemWrite latched.

Behaviour:
- Reset is synchronous, active-high, and wins over all other inputs. On the edge with RST=1, every register clears: dREN=0, dWEN=0, timeout=0, conflict=0, halted=0, halt_pend=0, all counters=0. iREN is combinational and equals 1 after reset. Reset mid-request drops all enables on the next edge with no completion required.
- Request latch, per channel i, evaluated at each edge in priority order:
  - ihit=1 and not halt_pend: dREN[i]<=MemRead[i]&~MemWrite[i]; dWEN[i]<=MemWrite[i].
  - Else if dhit[i]=1: dREN[i]<=0; dWEN[i]<=0.
  - Otherwise hold.
- Latency: enables rise one cycle after ihit. They fall one cycle after dhit.
- ihit and dhit[i] in the same cycle: the new request wins and replaces the old one.
- Read/write conflict: MemRead[i]&MemWrite[i] latched on ihit -> write wins. conflict pulses high for exactly the next cycle, whichever channel caused it.
- dREN[i] and dWEN[i] are never high together.
- dhit[i] with no request outstanding is ignored.
- iREN = ~halt_pend & ~halted & ~(ISTALL_EN & busy).
- Halt state machine, states RUN -> DRAIN -> HALTED:
  - RUN: halt=1 at an edge -> DRAIN. halt_pend=1 and iREN drops. Requests latched on that same edge (ihit with halt) are still accepted.
  - DRAIN: no new requests are latched. When busy=0 at an edge (including the edge where the last dhit clears it) -> HALTED.
  - RUN with halt=1 and busy=0 after that edge's update -> HALTED directly.
  - HALTED: halted=1 and all enables stay 0 until RST. halt deasserting does not leave HALTED.
- Watchdog, per channel, when TIMEOUT>0:
  - cnt[i] clears on any edge where the channel is idle, receives dhit, or has a request newly latched.
  - Otherwise cnt[i] increments, saturating at TIMEOUT.
  - timeout[i] sets on the edge where cnt[i] reaches TIMEOUT, i.e. TIMEOUT cycles after the request rises. It clears on that channel's dhit edge.
  - The request is not dropped on timeout.
- TIMEOUT=0: counters are held at 0 and timeout stays 0.
- busy and iREN are combinational from registered state only; there is no combinational path from dhit or ihit.

Test Plan:
- Reset then idle (NCH=2): RST=1 for 2 cycles -> iREN=1, dREN=dWEN=00, halted=0. Then ihit=1 with MemRead=01 -> dREN=01 the next cycle, iREN=0 (ISTALL_EN=1). dhit=01 -> dREN=00 and iREN=1 the next cycle.
- Same-cycle replace: with dWEN=10 pending, ihit=1, dhit=10 and MemRead=10 together -> next cycle dREN=10, dWEN=00.
- Conflict: ihit with MemRead=01 and MemWrite=01 -> dWEN=01, dREN=00, conflict=1 for exactly one cycle.
- Halt drain: dREN=11 pending, halt=1 -> iREN=0 next cycle, halted=0. dhit=01, then dhit=10 two cycles later -> halted=1 on the edge clearing the last request. halted stays 1 after halt drops, until RST.
- Watchdog (TIMEOUT=4): dREN[0] rises and no dhit arrives -> timeout=01 exactly 4 cycles after dREN rises, dREN held at 1. dhit=01 -> timeout=00 and dREN=00 the next cycle.
- Reset mid-request: dWEN=01 and timeout=01 set, RST=1 for one edge -> all outputs at reset values the next cycle, iREN=1.

Source files
------------

// File: rtl/request_unit_mc.sv
// Multi-channel memory request unit: fetch enable, per-channel data enables,
// halt draining, request watchdogs and read/write conflict detection.
module request_unit_mc #(
    parameter int NCH       = 2,
    parameter bit ISTALL_EN = 1'b1,
    parameter int TIMEOUT   = 64,
    parameter int TW        = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           halt,
    input  logic           ihit,
    input  logic [NCH-1:0] dhit,
    input  logic [NCH-1:0] MemRead,
    input  logic [NCH-1:0] MemWrite,
    output logic           iREN,
    output logic [NCH-1:0] dREN,
    output logic [NCH-1:0] dWEN,
    output logic           busy,
    output logic           halted,
    output logic [NCH-1:0] timeout,
    output logic           conflict
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    state_t         state_q, state_d;
    logic [NCH-1:0] dren_q, dren_d;
    logic [NCH-1:0] dwen_q, dwen_d;
    logic [NCH-1:0] to_q, to_d;
    logic           conf_q, conf_d;
    logic [TW-1:0]  cnt_q [NCH];
    logic [TW-1:0]  cnt_d [NCH];
    logic           accept;
    logic           busy_d;

    always_comb begin
        accept = ihit && (state_q == RUN);
        dren_d = dren_q & ~dhit;
        dwen_d = dwen_q & ~dhit;
        if (accept) begin
            // a simultaneous read and write request resolves to the write
            dren_d = MemRead & ~MemWrite;
            dwen_d = MemWrite;
        end
        conf_d = accept && (|(MemRead & MemWrite));
        busy_d = |(dren_d | dwen_d);

        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt) state_d = busy_d ? DRAIN : HALTED;
            end
            DRAIN: begin
                if (!busy_d) state_d = HALTED;
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase

        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            to_d[i]  = 1'b0;
            if (TIMEOUT != 0) begin
                if (!(dren_q[i] || dwen_q[i]) || dhit[i] || accept)
                    cnt_d[i] = '0;
                else if (cnt_q[i] != TMAX)
                    cnt_d[i] = cnt_q[i] + 1'b1;
                else
                    cnt_d[i] = cnt_q[i];
                to_d[i] = !dhit[i] && (to_q[i] || (cnt_d[i] == TMAX));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            dren_q  <= '0;
            dwen_q  <= '0;
            to_q    <= '0;
            conf_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            to_q    <= to_d;
            conf_q  <= conf_d;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign dREN     = dren_q;
    assign dWEN     = dwen_q;
    assign busy     = |(dren_q | dwen_q);
    assign halted   = (state_q == HALTED);
    assign timeout  = to_q;
    assign conflict = conf_q;
    assign iREN     = (state_q == RUN) && !(ISTALL_EN && busy);

endmodule

// File: tb/tb_request_unit_mc.sv
// Bench for request_unit_mc: directed scenarios then random traffic,
// all checked against a per-channel request/age reference model.
module tb_request_unit_mc;

    localparam int NCH = 2;
    localparam int TO  = 4;

    logic           CLK = 1'b0;
    logic           RST, halt, ihit;
    logic [NCH-1:0] dhit, MemRead, MemWrite;
    logic           iREN, busy, halted, conflict;
    logic [NCH-1:0] dREN, dWEN, timeout;

    int total = 0;
    int bad   = 0;

    // reference model: 0 idle, 1 read pending, 2 write pending
    int kind [NCH];
    int age  [NCH];
    bit tflag[NCH];
    bit m_conf;
    bit m_pend;
    bit m_stop;

    request_unit_mc #(
        .NCH(NCH), .ISTALL_EN(1'b1), .TIMEOUT(TO), .TW(8)
    ) dut (
        .CLK(CLK), .RST(RST), .halt(halt), .ihit(ihit),
        .dhit(dhit), .MemRead(MemRead), .MemWrite(MemWrite),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .busy(busy),
        .halted(halted), .timeout(timeout), .conflict(conflict)
    );

    always #5 CLK = ~CLK;

    task automatic model_edge();
        bit acc, any;
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                kind[i] = 0; age[i] = 0; tflag[i] = 0;
            end
            m_conf = 0; m_pend = 0; m_stop = 0;
            return;
        end
        acc = ihit && !m_pend && !m_stop;
        m_conf = 0;
        any = 0;
        for (int i = 0; i < NCH; i++) begin
            bit was = (kind[i] != 0);
            if (acc) begin
                kind[i] = MemWrite[i] ? 2 : (MemRead[i] ? 1 : 0);
                if (MemRead[i] && MemWrite[i]) m_conf = 1;
            end else if (dhit[i]) begin
                kind[i] = 0;
            end
            if (!was || dhit[i] || acc) age[i] = 0;
            else if (age[i] < TO) age[i] = age[i] + 1;
            if (dhit[i]) tflag[i] = 0;
            else if (age[i] == TO) tflag[i] = 1;
            if (kind[i] != 0) any = 1;
        end
        if (!m_pend && !m_stop && halt) begin
            if (any) m_pend = 1; else m_stop = 1;
        end else if (m_pend && !any) begin
            m_pend = 0; m_stop = 1;
        end
    endtask

    task automatic check(input string tag);
        logic [NCH-1:0] er, ew, et;
        logic eb, ei;
        eb = 0;
        for (int i = 0; i < NCH; i++) begin
            er[i] = (kind[i] == 1);
            ew[i] = (kind[i] == 2);
            et[i] = tflag[i];
            if (kind[i] != 0) eb = 1;
        end
        ei = !m_pend && !m_stop && !eb;
        total++;
        assert (dREN === er) else begin
            bad++; $error("FAIL %s dREN got=%b exp=%b", tag, dREN, er);
        end
        total++;
        assert (dWEN === ew) else begin
            bad++; $error("FAIL %s dWEN got=%b exp=%b", tag, dWEN, ew);
        end
        total++;
        assert (timeout === et) else begin
            bad++; $error("FAIL %s timeout got=%b exp=%b", tag, timeout, et);
        end
        total++;
        assert (busy === eb) else begin
            bad++; $error("FAIL %s busy got=%b exp=%b", tag, busy, eb);
        end
        total++;
        assert (iREN === ei) else begin
            bad++; $error("FAIL %s iREN got=%b exp=%b", tag, iREN, ei);
        end
        total++;
        assert (halted === m_stop) else begin
            bad++; $error("FAIL %s halted got=%b exp=%b", tag, halted, m_stop);
        end
        total++;
        assert (conflict === m_conf) else begin
            bad++; $error("FAIL %s conflict got=%b exp=%b", tag, conflict, m_conf);
        end
    endtask

    task automatic pin(input string tag, input logic [NCH-1:0] got,
                       input logic [NCH-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic h,
                        input logic ih, input logic [NCH-1:0] dh,
                        input logic [NCH-1:0] mr, input logic [NCH-1:0] mw);
        RST = r; halt = h; ihit = ih; dhit = dh; MemRead = mr; MemWrite = mw;
        @(posedge CLK);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        RST = 1; halt = 0; ihit = 0; dhit = 0; MemRead = 0; MemWrite = 0;
        for (int i = 0; i < NCH; i++) begin
            kind[i] = 0; age[i] = 0; tflag[i] = 0;
        end
        m_conf = 0; m_pend = 0; m_stop = 0;

        step("rst0", 1, 0, 0, 2'b00, 2'b00, 2'b00);
        step("rst1", 1, 0, 0, 2'b00, 2'b00, 2'b00);
        pin("rst_iren", {1'b0, iREN}, 2'b01);
        pin("rst_dren", dREN, 2'b00);

        step("rd_req", 0, 0, 1, 2'b00, 2'b01, 2'b00);
        pin("rd_dren", dREN, 2'b01);
        pin("rd_stall", {1'b0, iREN}, 2'b00);
        step("rd_hold", 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("rd_hit", 0, 0, 0, 2'b01, 2'b00, 2'b00);
        pin("rd_done", {dREN[0], iREN}, 2'b01);

        step("wr_req", 0, 0, 1, 2'b00, 2'b00, 2'b10);
        pin("wr_dwen", dWEN, 2'b10);
        step("replace", 0, 0, 1, 2'b10, 2'b10, 2'b00);
        pin("rep_dren", dREN, 2'b10);
        pin("rep_dwen", dWEN, 2'b00);
        step("rep_hit", 0, 0, 0, 2'b10, 2'b00, 2'b00);
        step("stray", 0, 0, 0, 2'b11, 2'b00, 2'b00);

        step("conf", 0, 0, 1, 2'b00, 2'b01, 2'b01);
        pin("conf_pulse", {1'b0, conflict}, 2'b01);
        pin("conf_dwen", dWEN, 2'b01);
        step("conf_end", 0, 0, 0, 2'b00, 2'b00, 2'b00);
        pin("conf_low", {1'b0, conflict}, 2'b00);
        step("conf_hit", 0, 0, 0, 2'b01, 2'b00, 2'b00);

        step("h_req", 0, 0, 1, 2'b00, 2'b11, 2'b00);
        step("h_set", 0, 1, 0, 2'b00, 2'b00, 2'b00);
        pin("h_iren", {halted, iREN}, 2'b00);
        step("h_ign", 0, 1, 1, 2'b00, 2'b00, 2'b11);
        step("h_d0", 0, 1, 0, 2'b01, 2'b00, 2'b00);
        step("h_wait", 0, 0, 0, 2'b00, 2'b00, 2'b00);
        step("h_d1", 0, 0, 0, 2'b10, 2'b00, 2'b00);
        pin("h_done", {1'b0, halted}, 2'b01);
        step("h_stay", 0, 0, 1, 2'b00, 2'b01, 2'b00);
        pin("h_sticky", {halted, iREN}, 2'b10);
        step("h_rst", 1, 0, 0, 2'b00, 2'b00, 2'b00);

        step("wd_req", 0, 0, 1, 2'b00, 2'b01, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            step("wd_wait", 0, 0, 0, 2'b00, 2'b00, 2'b00);
            pin("wd_tmo", timeout, (k == 4) ? 2'b01 : 2'b00);
        end
        step("wd_hold", 0, 0, 0, 2'b00, 2'b00, 2'b00);
        pin("wd_held", dREN, 2'b01);
        step("wd_hit", 0, 0, 0, 2'b01, 2'b00, 2'b00);
        pin("wd_clr", timeout | dREN, 2'b00);

        step("mr_req", 0, 0, 1, 2'b00, 2'b00, 2'b01);
        for (int k = 0; k < 4; k++)
            step("mr_wait", 0, 0, 0, 2'b00, 2'b00, 2'b00);
        pin("mr_tmo", timeout, 2'b01);
        step("mr_rst", 1, 0, 1, 2'b01, 2'b01, 2'b01);
        pin("mr_out", dWEN | timeout, 2'b00);
        pin("mr_iren", {1'b0, iREN}, 2'b01);

        for (int n = 0; n < 3000; n++) begin
            step("rand",
                 ($urandom % 120) == 0,
                 ($urandom % 200) == 0,
                 ($urandom % 3) == 0,
                 {($urandom % 6) == 0, ($urandom % 6) == 0},
                 NCH'($urandom), NCH'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
